l1_l2_bus_requester: RTL and testbench

- Initiator side of the L1→L2 bus: accepts one load/store request at a time from an L1 data-cache controller and drives opcode, address and write data to cache_subsystem_L2.
- Loads: interprets the 2-bit L2 hit/miss code. On an L2 miss, fetches the word from data memory, then replays it to L2 so L2 refills.
- Returns load data, or store completion, to L1 with a one-cycle response pulse.
- Keeps saturating hit/miss statistics counters.

---
 rtl/l1_l2_bus_requester.sv | 189 ++++++++++++++++++
 tb/tb_l1_l2_bus_requester.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_bus_requester.sv
// L1->L2 bus initiator: issues one load/store at a time to L2.
// On an L2 load miss it fetches the word from dmem and replays it to L2.
module l1_l2_bus_requester #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_data,
  output logic             resp_error,
  output logic             busy,
  output logic [6:0]       opcode_out,
  output logic [31:0]      bus_address_out,
  output logic [31:0]      bus_data_out,
  input  logic [1:0]       l2_hit_in,
  input  logic [31:0]      l2_data_in,
  output logic             dmem_rd_en,
  output logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_rvalid,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT_L2 = 3'd2;
  localparam logic [2:0] MEM_RD  = 3'd3;
  localparam logic [2:0] FILL    = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             store_q, store_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    store_d = store_q;
    data_d  = data_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          store_d = req_is_store;
          data_d  = '0;
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE, WAIT_L2: begin
        if (state_q == ISSUE && store_q) begin
          state_d = RESP;
        end else if (l2_hit_in == 2'b10) begin
          data_d  = l2_data_in;
          hit_d   = (&hit_q) ? hit_q : hit_q + CNT_ONE;
          state_d = RESP;
        end else if (l2_hit_in == 2'b01) begin
          miss_d  = (&miss_q) ? miss_q : miss_q + CNT_ONE;
          tmo_d   = TMO_ONE;
          state_d = MEM_RD;
        end else if (state_q == WAIT_L2 && tmo_q >= TMO_MAX) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = RESP;
        end else begin
          tmo_d   = (state_q == ISSUE) ? TMO_ONE : tmo_q + TMO_ONE;
          state_d = WAIT_L2;
        end
      end
      MEM_RD: begin
        if (dmem_rvalid) begin
          data_d  = dmem_rdata;
          state_d = FILL;
        end else if (tmo_q >= TMO_MAX) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      FILL:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Bus outputs are pure decodes of the state and latched request.
  always_comb begin
    req_ready       = 1'b0;
    busy            = 1'b1;
    resp_valid      = 1'b0;
    resp_data       = '0;
    resp_error      = 1'b0;
    opcode_out      = '0;
    bus_address_out = '0;
    bus_data_out    = '0;
    dmem_rd_en      = 1'b0;
    dmem_addr       = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ISSUE: begin
        opcode_out      = store_q ? OP_STORE : OP_LOAD;
        bus_address_out = addr_q;
        bus_data_out    = store_q ? wdata_q : 32'd0;
      end
      WAIT_L2: begin
        opcode_out      = OP_LOAD;
        bus_address_out = addr_q;
      end
      MEM_RD: begin
        dmem_rd_en = 1'b1;
        dmem_addr  = addr_q;
      end
      FILL: begin
        opcode_out      = OP_LOAD;
        bus_address_out = addr_q;
        bus_data_out    = data_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = data_q;
        resp_error = err_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_l1_l2_bus_requester.sv
// Directed bench for l1_l2_bus_requester with TIMEOUT_CYCLES=4
// and 3-bit counters so saturation is reachable.
module tb_l1_l2_bus_requester;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        busy;
  logic [6:0]  opcode_out;
  logic [31:0] bus_address_out;
  logic [31:0] bus_data_out;
  logic [1:0]  l2_hit_in;
  logic [31:0] l2_data_in;
  logic        dmem_rd_en;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [2:0]  hit_count;
  logic [2:0]  miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1_l2_bus_requester #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_is_store(req_is_store),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_error(resp_error),
    .busy(busy),
    .opcode_out(opcode_out),
    .bus_address_out(bus_address_out),
    .bus_data_out(bus_data_out),
    .l2_hit_in(l2_hit_in),
    .l2_data_in(l2_data_in),
    .dmem_rd_en(dmem_rd_en),
    .dmem_addr(dmem_addr),
    .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  // dlat: MEM_RD cycle (1-based) carrying dmem_rvalid, 0 = never.
  // sw/code2: l2_hit_in switches to code2 at that cycle, 0 = never.
  typedef struct {
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  code;
    logic [31:0] l2d;
    int          dlat;
    logic [31:0] drd;
    int          sw;
    logic [1:0]  code2;
    logic [31:0] edata;
    logic        eerr;
    int          elat;
    logic        efill;
    int          ehit;
    int          emiss;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int cyc;
    int rd;
    int fills;
    logic done;
    logic [31:0] fd;
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), req_ready, 1);
    req_valid    = 1'b1;
    req_is_store = v.st;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    l2_hit_in    = v.code;
    l2_data_in   = v.l2d;
    dmem_rvalid  = 1'b0;
    dmem_rdata   = '0;
    cyc = 0;
    rd = 0;
    fills = 0;
    done = 1'b0;
    fd = '0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      req_valid   = 1'b0;
      dmem_rvalid = 1'b0;
      if (cyc == 1) begin
        chk($sformatf("v%0d issue op", idx), opcode_out,
            v.st ? OP_STORE : OP_LOAD);
        chk($sformatf("v%0d issue addr", idx), bus_address_out, v.addr);
        chk($sformatf("v%0d issue data", idx), bus_data_out,
            v.st ? v.wdata : 32'd0);
      end
      if (v.sw != 0 && cyc == v.sw) l2_hit_in = v.code2;
      if (dmem_rd_en) begin
        rd++;
        if (rd == 1) chk($sformatf("v%0d dmem addr", idx), dmem_addr, v.addr);
        if (rd == v.dlat) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = v.drd;
        end
      end else if (rd > 0 && opcode_out == OP_LOAD) begin
        fills++;
        fd = bus_data_out;
        chk($sformatf("v%0d fill addr", idx), bus_address_out, v.addr);
      end
      if (resp_valid) begin
        done = 1'b1;
        chk($sformatf("v%0d latency", idx), cyc, v.elat);
        chk($sformatf("v%0d resp data", idx), resp_data, v.edata);
        chk($sformatf("v%0d resp err", idx), resp_error, v.eerr);
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL v%0d resp timeout: got none expected resp_valid", idx);
    end
    chk($sformatf("v%0d fill cycles", idx), fills, v.efill ? 1 : 0);
    if (v.efill) chk($sformatf("v%0d fill data", idx), fd, v.drd);
    l2_hit_in = 2'b00;
    @(negedge clk);
    chk($sformatf("v%0d resp pulse", idx), resp_valid, 0);
    chk($sformatf("v%0d hit cnt", idx), hit_count, v.ehit);
    chk($sformatf("v%0d miss cnt", idx), miss_count, v.emiss);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req_valid = 1'b1;
    req_is_store = 1'b0;
    req_addr = 32'h400;
    req_wdata = 32'h0;
    l2_hit_in = 2'b10;
    l2_data_in = 32'h100;
    dmem_rdata = '0;
    dmem_rvalid = 1'b0;

    // {st, addr, wdata, code, l2d, dlat, drd, sw, code2,
    //  edata, eerr, elat, efill, ehit, emiss}
    tv.push_back('{0, 32'h400, 0, 2'b10, 32'h100, 0, 0, 0, 0,
                   32'h100, 0, 2, 0, 1, 0});
    tv.push_back('{0, 32'h800, 0, 2'b01, 0, 3, 32'hDEADBEEF, 0, 0,
                   32'hDEADBEEF, 0, 6, 1, 1, 1});
    tv.push_back('{1, 32'hC01, 32'h1234, 2'b10, 32'h999, 0, 0, 0, 0,
                   0, 0, 2, 0, 1, 1});
    tv.push_back('{0, 32'h10, 0, 2'b00, 0, 0, 0, 0, 0,
                   0, 1, 6, 0, 1, 1});
    tv.push_back('{0, 32'h14, 0, 2'b11, 32'h5, 0, 0, 0, 0,
                   0, 1, 6, 0, 1, 1});
    tv.push_back('{0, 32'h18, 0, 2'b01, 0, 0, 32'h77, 0, 0,
                   0, 1, 6, 0, 1, 2});
    tv.push_back('{0, 32'h1C, 0, 2'b01, 0, 4, 32'hCAFE, 0, 0,
                   32'hCAFE, 0, 7, 1, 1, 3});
    tv.push_back('{0, 32'h20, 0, 2'b01, 0, 1, 32'h55, 0, 0,
                   32'h55, 0, 4, 1, 1, 4});
    for (int i = 0; i < 7; i++)
      tv.push_back('{0, 32'h100 + i * 4, 0, 2'b10, 32'hA0 + i, 0, 0, 0, 0,
                     32'hA0 + i, 0, 2, 0, (i < 6) ? i + 2 : 7, 4});
    for (int i = 0; i < 4; i++)
      tv.push_back('{0, 32'h200 + i * 4, 0, 2'b01, 0, 1, 32'hB0 + i, 0, 0,
                     32'hB0 + i, 0, 4, 1, 7, (i < 3) ? i + 5 : 7});
    tv.push_back('{0, 32'h30, 0, 2'b00, 32'hABCD, 0, 0, 3, 2'b10,
                   32'hABCD, 0, 4, 0, 7, 7});
    tv.push_back('{0, 32'h34, 0, 2'b11, 32'h4321, 0, 0, 5, 2'b10,
                   32'h4321, 0, 6, 0, 7, 7});

    repeat (3) begin
      @(negedge clk);
      chk("rst ready", req_ready, 1);
      chk("rst busy", busy, 0);
      chk("rst resp_valid", resp_valid, 0);
      chk("rst resp_error", resp_error, 0);
      chk("rst resp_data", resp_data, 0);
      chk("rst opcode", opcode_out, 0);
      chk("rst bus addr", bus_address_out, 0);
      chk("rst bus data", bus_data_out, 0);
      chk("rst dmem_rd_en", dmem_rd_en, 0);
      chk("rst dmem_addr", dmem_addr, 0);
      chk("rst hits", hit_count, 0);
      chk("rst misses", miss_count, 0);
    end
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post rst idle", req_ready, 1);
    chk("post rst busy", busy, 0);

    for (int i = 0; i < tv.size(); i++) run(tv[i], i);

    // reset while waiting on dmem aborts silently
    @(negedge clk);
    req_valid = 1'b1;
    req_is_store = 1'b0;
    req_addr = 32'h40;
    l2_hit_in = 2'b01;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (n < 2) begin
      @(negedge clk);
      if (dmem_rd_en) n++;
      chk("abort no resp", resp_valid, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort rd_en", dmem_rd_en, 0);
    chk("abort ready", req_ready, 1);
    chk("abort resp", resp_valid, 0);
    chk("abort hits", hit_count, 0);
    chk("abort misses", miss_count, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort idle resp", resp_valid, 0);
      chk("abort idle busy", busy, 0);
    end
    run('{0, 32'h44, 0, 2'b10, 32'h77, 0, 0, 0, 0,
          32'h77, 0, 2, 0, 1, 0}, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
